axi4lite_slave_regs: RTL and testbench
======================================

# axi4lite_slave_regs

AXI4-Lite slave endpoint that terminates the slave side of the `axi4lite_bfm` bus and backs it with a bank of `NUMREGS` read/write data registers. It sits directly downstream of the bus interface: a master drives AW/W/AR through `slave_if`, and this block returns B/R handshakes and read data. The write and read channels are independent FSMs, so one write and one read can be in flight at the same time. There are no response codes.

## Interface
- `NUMREGS`, 16: number of `DATAWIDTH`-bit registers; power of two, ≥2.
- `ADDRWIDTH`, `axi4lite_pkg::ADDRWIDTH`: bus address width.
- `DATAWIDTH`, `axi4lite_pkg::DATAWIDTH`: bus data width; multiple of 8.
- `ACLK` in 1: system clock; one clock domain, all logic on the rising edge.
- `ARESETN` in 1: asynchronous, active-low reset.
- `AWADDR` in `ADDRWIDTH`: write address.
- `AWVALID` in 1 / `AWREADY` out 1: write-address handshake.
- `WDATA` in `DATAWIDTH`: write data.
- `WVALID` in 1 / `WREADY` out 1: write-data handshake.
- `BVALID` out 1 / `BREADY` in 1: write-response handshake.
- `ARADDR` in `ADDRWIDTH`: read address.
- `ARVALID` in 1 / `ARREADY` out 1: read-address handshake.
- `RDATA` out `DATAWIDTH` / `RVALID` out 1 / `RREADY` in 1: read-data handshake.

## Operation
- Addresses are byte addresses. `LSB = log2(DATAWIDTH/8)`; word index = `addr[LSB +: log2(NUMREGS)]`.
- An address is in range when `addr < NUMREGS*(DATAWIDTH/8)`. Address bits below `LSB` are ignored.
- Out-of-range write: handshakes complete normally and no register changes.
- Out-of-range read: handshakes complete normally and `RDATA` = 0.
- Write FSM states:
  - `W_IDLE`: `AWREADY`=`WREADY`=1.
  - `W_HAVE_A`: `WREADY`=1 only.
  - `W_HAVE_D`: `AWREADY`=1 only.
  - `W_RESP`: `BVALID`=1, both readies 0.
- Write FSM transitions:
  - `W_IDLE` with AW and W handshakes on the same edge → register written on that edge → `W_RESP`.
  - `W_IDLE` with AW only → latch address → `W_HAVE_A`.
  - `W_IDLE` with W only → latch data → `W_HAVE_D`.
  - `W_HAVE_A`/`W_HAVE_D`: completing handshake writes the register → `W_RESP`.
  - `W_RESP` with `BREADY` → `W_IDLE`.
- Read FSM states:
  - `R_IDLE`: `ARREADY`=1.
  - `R_DATA`: `RVALID`=1, `RDATA` registered and held stable.
- Read FSM transitions:
  - `R_IDLE` with AR handshake → capture register value into `RDATA` → `R_DATA`.
  - `R_DATA` with `RREADY` → `R_IDLE`.
- Read and write to the same register on the same edge: the read returns the pre-write value.

## Timing
- During reset, all registers, `RDATA`, `BVALID`, `RVALID` and every ready are 0, and both FSMs are idle.
- All outputs are registered. Readies rise on the first `ACLK` edge after `ARESETN` deasserts.
- Write latency: `BVALID` rises on the edge of the last of the AW/W handshakes and is visible the following cycle.
- Read latency: `RVALID`/`RDATA` are valid the cycle after the AR handshake.
- Back-to-back throughput is one write per 2 cycles and one read per 2 cycles when `BREADY`/`RREADY` are held high.
- A master stalling `BREADY`/`RREADY` holds `BVALID`/`RVALID` and `RDATA` indefinitely. No new AW/W/AR is accepted meanwhile.
- Reset asserted mid-transaction aborts it. A partially latched address or data is discarded, and a register write that has not yet committed does not occur.

## Structure
- `axi4lite_pkg` gains `typedef enum` types `wr_state_t` (`W_IDLE`, `W_HAVE_A`, `W_HAVE_D`, `W_RESP`) and `rd_state_t` (`R_IDLE`, `R_DATA`).
- `ADDRWIDTH`/`DATAWIDTH` remain in `axi4lite_pkg`.
- Top module connects to `axi4lite_bfm.slave_if`.
- One sub-module, `axi4lite_regfile`: `NUMREGS`×`DATAWIDTH` array with one synchronous write port, one combinational read port, and async reset to 0.

## Test plan
- Reset then idle: all outputs 0 while `ARESETN`=0. One cycle after release, `AWREADY`=`WREADY`=`ARREADY`=1 and `BVALID`=`RVALID`=0.
- Write `0xDEADBEEF` to `0x08` with AW and W together, `BREADY`=1 → `BVALID` one cycle later. Then read `0x08` → `RDATA`=`0xDEADBEEF` with `RVALID` one cycle after AR.
- Channel ordering at `0x04` → register updated and exactly one `BVALID` pulse for each case:
  - W first (`0x12345678`), AW 3 cycles later.
  - AW first, W 2 cycles later.
- Out-of-range: write `0xFFFFFFFF` to `NUMREGS*4` → `BVALID` returned and no register changes. Read `NUMREGS*4` → `RDATA`=0.
- Stalls: hold `RREADY`=0 for 5 cycles → `RVALID`/`RDATA` stable and `ARREADY`=0 throughout. Same for `BREADY` with `BVALID`, `AWREADY` and `WREADY`.
- Collision and abort:
  - Register 2 holds `0x11`. Write `0x22` to it and read it on the same edge → read returns `0x11`, and a later read returns `0x22`.
  - Assert `ARESETN` in `W_HAVE_A` → no write occurs and all registers are 0.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite bus widths and the slave register-block FSM state types.
package axi4lite_pkg;

    localparam int ADDRWIDTH = 32;
    localparam int DATAWIDTH = 32;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_HAVE_A = 2'd1,
        W_HAVE_D = 2'd2,
        W_RESP   = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi4lite_regfile.sv
// NUMREGS x DATAWIDTH register array: one synchronous write port, one combinational read port.
// Zero latency on read; writes land on the clock edge, no backpressure.
module axi4lite_regfile #(
    parameter int NUMREGS   = 16,
    parameter int DATAWIDTH = 32,
    parameter int IDXW      = $clog2(NUMREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [IDXW-1:0]      wr_idx,
    input  logic [DATAWIDTH-1:0] wr_dat,
    input  logic [IDXW-1:0]      rd_idx,
    output logic [DATAWIDTH-1:0] rd_dat
);

    logic [NUMREGS-1:0][DATAWIDTH-1:0] regs_q;
    logic [NUMREGS-1:0][DATAWIDTH-1:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_idx] = wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads see the pre-edge contents, so a same-edge write is not visible yet.
    assign rd_dat = regs_q[rd_idx];

endmodule

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave backed by a register bank; independent write and read FSMs, all outputs registered.
// B/R valid one cycle after the completing handshake; stalled B/R block new requests on that channel.
module axi4lite_slave_regs #(
    parameter int NUMREGS   = 16,
    parameter int ADDRWIDTH = axi4lite_pkg::ADDRWIDTH,
    parameter int DATAWIDTH = axi4lite_pkg::DATAWIDTH
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic [ADDRWIDTH-1:0] AWADDR,
    input  logic                 AWVALID,
    output logic                 AWREADY,
    input  logic [DATAWIDTH-1:0] WDATA,
    input  logic                 WVALID,
    output logic                 WREADY,
    output logic                 BVALID,
    input  logic                 BREADY,
    input  logic [ADDRWIDTH-1:0] ARADDR,
    input  logic                 ARVALID,
    output logic                 ARREADY,
    output logic [DATAWIDTH-1:0] RDATA,
    output logic                 RVALID,
    input  logic                 RREADY
);

    import axi4lite_pkg::*;

    localparam int                 LSB        = $clog2(DATAWIDTH / 8);
    localparam int                 IDXW       = $clog2(NUMREGS);
    localparam logic [ADDRWIDTH-1:0] ADDR_LIMIT = ADDRWIDTH'(NUMREGS * (DATAWIDTH / 8));

    function automatic logic in_range(input logic [ADDRWIDTH-1:0] addr);
        return addr < ADDR_LIMIT;
    endfunction

    function automatic logic [IDXW-1:0] word_idx(input logic [ADDRWIDTH-1:0] addr);
        return addr[LSB +: IDXW];
    endfunction

    wr_state_t            wr_state_q, wr_state_d;
    rd_state_t            rd_state_q, rd_state_d;
    logic [ADDRWIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATAWIDTH-1:0] wdata_q, wdata_d;
    logic [DATAWIDTH-1:0] rdata_q, rdata_d;
    logic                 awready_q, awready_d;
    logic                 wready_q, wready_d;
    logic                 bvalid_q, bvalid_d;
    logic                 arready_q, arready_d;
    logic                 rvalid_q, rvalid_d;

    logic                 aw_hs, w_hs, ar_hs;
    logic                 wr_commit;
    logic [ADDRWIDTH-1:0] wr_addr;
    logic [DATAWIDTH-1:0] wr_dat;
    logic                 rf_wr_en;
    logic [DATAWIDTH-1:0] rf_rd_dat;

    assign aw_hs = AWVALID && awready_q;
    assign w_hs  = WVALID && wready_q;
    assign ar_hs = ARVALID && arready_q;

    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wr_commit  = 1'b0;
        wr_addr    = awaddr_q;
        wr_dat     = wdata_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_commit  = 1'b1;
                    wr_addr    = AWADDR;
                    wr_dat     = WDATA;
                    wr_state_d = W_RESP;
                end else if (aw_hs) begin
                    awaddr_d   = AWADDR;
                    wr_state_d = W_HAVE_A;
                end else if (w_hs) begin
                    wdata_d    = WDATA;
                    wr_state_d = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                if (w_hs) begin
                    wr_commit  = 1'b1;
                    wr_dat     = WDATA;
                    wr_state_d = W_RESP;
                end
            end
            W_HAVE_D: begin
                if (aw_hs) begin
                    wr_commit  = 1'b1;
                    wr_addr    = AWADDR;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
        // Readies/valids are decoded from the next state so they come straight off flops.
        awready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_D);
        wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_A);
        bvalid_d  = (wr_state_d == W_RESP);
    end

    assign rf_wr_en = wr_commit && in_range(wr_addr);

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rdata_d    = in_range(ARADDR) ? rf_rd_dat : '0;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        arready_d = (rd_state_d == R_IDLE);
        rvalid_d  = (rd_state_d == R_DATA);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
        end
    end

    axi4lite_regfile #(
        .NUMREGS   (NUMREGS),
        .DATAWIDTH (DATAWIDTH),
        .IDXW      (IDXW)
    ) u_regfile (
        .clk    (ACLK),
        .rst_n  (ARESETN),
        .wr_en  (rf_wr_en),
        .wr_idx (word_idx(wr_addr)),
        .wr_dat (wr_dat),
        .rd_idx (word_idx(ARADDR)),
        .rd_dat (rf_rd_dat)
    );

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Directed bench for axi4lite_slave_regs: inputs driven and outputs sampled on the falling edge.
module tb_axi4lite_slave_regs;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic        WVALID;
    logic        WREADY;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic        RVALID;
    logic        RREADY;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 ACLK = ~ACLK;

    axi4lite_slave_regs #(.NUMREGS(16), .ADDRWIDTH(32), .DATAWIDTH(32)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .AWADDR  (AWADDR),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    // Both channels presented together; each drops once its own handshake is seen.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input string tag);
        AWADDR = addr; WDATA = data; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        for (int i = 0; i < 20 && (AWVALID || WVALID); i++) begin
            logic a, w;
            a = AWVALID && AWREADY;
            w = WVALID && WREADY;
            tick();
            if (a) AWVALID = 1'b0;
            if (w) WVALID = 1'b0;
        end
        chk({tag, "_hs"}, {31'b0, AWVALID | WVALID}, 32'd0);
        AWVALID = 1'b0; WVALID = 1'b0;
        chk({tag, "_bvalid"}, {31'b0, BVALID}, 32'd1);
        tick();
        chk({tag, "_bdone"}, {31'b0, BVALID}, 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] d);
        ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
        for (int i = 0; i < 20 && ARVALID; i++) begin
            logic a;
            a = ARREADY;
            tick();
            if (a) ARVALID = 1'b0;
        end
        chk("rd_hs", {31'b0, ARVALID}, 32'd0);
        ARVALID = 1'b0;
        chk("rd_rvalid", {31'b0, RVALID}, 32'd1);
        d = RDATA;
        tick();
    endtask

    initial begin
        logic [31:0] d;
        int          bcnt;

        ARESETN = 1'b0;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("rst_awready", {31'b0, AWREADY}, 32'd0);
        chk("rst_wready",  {31'b0, WREADY},  32'd0);
        chk("rst_arready", {31'b0, ARREADY}, 32'd0);
        chk("rst_bvalid",  {31'b0, BVALID},  32'd0);
        chk("rst_rvalid",  {31'b0, RVALID},  32'd0);
        chk("rst_rdata",   RDATA,            32'd0);

        ARESETN = 1'b1;
        tick();
        chk("idle_awready", {31'b0, AWREADY}, 32'd1);
        chk("idle_wready",  {31'b0, WREADY},  32'd1);
        chk("idle_arready", {31'b0, ARREADY}, 32'd1);
        chk("idle_bvalid",  {31'b0, BVALID},  32'd0);
        chk("idle_rvalid",  {31'b0, RVALID},  32'd0);

        axi_write(32'h08, 32'hDEADBEEF, "wr08");
        axi_read(32'h08, d);
        chk("rd08", d, 32'hDEADBEEF);

        // W first, AW three cycles later
        WDATA = 32'h12345678; WVALID = 1'b1; BREADY = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("wf_awready", {31'b0, AWREADY}, 32'd1);
        chk("wf_wready",  {31'b0, WREADY},  32'd0);
        bcnt = 0;
        repeat (2) begin if (BVALID) bcnt++; tick(); end
        AWADDR = 32'h04; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("wf_bvalid", {31'b0, BVALID}, 32'd1);
        repeat (6) begin if (BVALID) bcnt++; tick(); end
        chk("wf_bpulses", bcnt, 32'd1);
        axi_read(32'h04, d);
        chk("wf_rd04", d, 32'h12345678);

        // AW first, W two cycles later
        AWADDR = 32'h04; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("af_wready",  {31'b0, WREADY},  32'd1);
        chk("af_awready", {31'b0, AWREADY}, 32'd0);
        bcnt = 0;
        if (BVALID) bcnt++;
        tick();
        WDATA = 32'hA5A50F0F; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        repeat (6) begin if (BVALID) bcnt++; tick(); end
        chk("af_bpulses", bcnt, 32'd1);
        axi_read(32'h04, d);
        chk("af_rd04", d, 32'hA5A50F0F);

        // Out of range: 0x40 and 0x48 would alias registers 0 and 2 if decoded
        axi_write(32'h40, 32'hFFFFFFFF, "oor40");
        axi_write(32'h48, 32'hFFFFFFFF, "oor48");
        axi_read(32'h00, d); chk("oor_rd00", d, 32'h0);
        axi_read(32'h04, d); chk("oor_rd04", d, 32'hA5A50F0F);
        axi_read(32'h08, d); chk("oor_rd08", d, 32'hDEADBEEF);
        axi_read(32'h40, d); chk("oor_rd40", d, 32'h0);
        axi_read(32'h48, d); chk("oor_rd48", d, 32'h0);
        axi_read(32'h0B, d); chk("rd0b_lowbits", d, 32'hDEADBEEF);

        // Read stall
        ARADDR = 32'h08; ARVALID = 1'b1; RREADY = 1'b0;
        tick();
        ARVALID = 1'b0;
        repeat (5) begin
            chk("rs_rvalid",  {31'b0, RVALID},  32'd1);
            chk("rs_rdata",   RDATA,            32'hDEADBEEF);
            chk("rs_arready", {31'b0, ARREADY}, 32'd0);
            tick();
        end
        RREADY = 1'b1;
        tick();
        chk("rs_rdone",   {31'b0, RVALID},  32'd0);
        chk("rs_arready_back", {31'b0, ARREADY}, 32'd1);

        // Write stall
        AWADDR = 32'h0C; WDATA = 32'hC0C0C0C0; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        repeat (5) begin
            chk("ws_bvalid",  {31'b0, BVALID},  32'd1);
            chk("ws_awready", {31'b0, AWREADY}, 32'd0);
            chk("ws_wready",  {31'b0, WREADY},  32'd0);
            tick();
        end
        BREADY = 1'b1;
        tick();
        chk("ws_bdone", {31'b0, BVALID}, 32'd0);
        axi_read(32'h0C, d);
        chk("ws_rd0c", d, 32'hC0C0C0C0);

        // Same-edge read and write of register 2
        axi_write(32'h08, 32'h11, "col_pre");
        AWADDR = 32'h08; WDATA = 32'h22; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 32'h08; ARVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        chk("col_rvalid", {31'b0, RVALID}, 32'd1);
        chk("col_rdata",  RDATA,           32'h11);
        chk("col_bvalid", {31'b0, BVALID}, 32'd1);
        tick();
        axi_read(32'h08, d);
        chk("col_rd_after", d, 32'h22);

        // Reset while holding an address only
        AWADDR = 32'h10; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("ab_wready",  {31'b0, WREADY},  32'd1);
        chk("ab_awready", {31'b0, AWREADY}, 32'd0);
        WDATA = 32'h99; WVALID = 1'b1;
        ARESETN = 1'b0;
        tick();
        chk("ab_rst_wready", {31'b0, WREADY}, 32'd0);
        chk("ab_rst_bvalid", {31'b0, BVALID}, 32'd0);
        chk("ab_rst_rdata",  RDATA,           32'd0);
        WVALID = 1'b0;
        ARESETN = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            axi_read(32'(i * 4), d);
            chk($sformatf("ab_reg%0d", i), d, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
